spi_master_param: RTL

Parametrised, full-duplex SPI master for the lab's serial-peripheral designs, generalising our fixed write-only SPI sequencer. Supports configurable word width, run-time clock divider, all four CPOL/CPHA modes, selectable bit order and up to N_CS chip selects. It sits between a command source (FSM or host register block) that pulses a start and the external SPI pins, returning the received word with a one-cycle completion pulse.

---
 rtl/spi_master_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master. Supports configurable word width,
// run-time divider, CPOL/CPHA, bit order and N_CS chip selects.
module spi_master_param #(
  parameter int  DATA_W    = 8,
  parameter int  DIV_W     = 8,
  parameter int  N_CS      = 4,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int SEL_W     = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              str_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [SEL_W-1:0]  cs_sel_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [N_CS-1:0]   cs_n_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, div_q;
  logic [BIT_W-1:0]    bit_q, nxt_idx, lead_idx;
  logic [DATA_W-1:0]   tx_q, rx_q;
  logic                cpol_q, cpha_q;
  logic                tick, last_bit, lead_entry, trail_entry;

  // Wire position of the i-th bit on the line within a word.
  function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] i);
    if (MSB_FIRST) return BIT_W'(DATA_W - 1) - i;
    return i;
  endfunction

  // First received bit ends up in the MSB for MSB-first, in the LSB otherwise.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r, input logic b);
    if (MSB_FIRST) return {r[DATA_W-2:0], b};
    return {b, r[DATA_W-1:1]};
  endfunction

  // Out-of-range selects leave every line deasserted.
  function automatic logic [N_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [N_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < N_CS; i++)
      if (SEL_W'(i) == sel) cs[i] = 1'b0;
    return cs;
  endfunction

  assign tick        = (cnt_q == div_q);
  assign last_bit    = (bit_q == BIT_W'(DATA_W - 1));
  assign nxt_idx     = bit_q + BIT_W'(1);
  assign lead_entry  = tick && ((state_q == SETUP) || (state_q == TRAIL && !last_bit));
  assign trail_entry = tick && (state_q == LEAD);
  assign lead_idx    = (state_q == TRAIL) ? nxt_idx : bit_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (str_i) state_d = SETUP;
      SETUP:   if (tick)  state_d = LEAD;
      LEAD:    if (tick)  state_d = TRAIL;
      TRAIL:   if (tick)  state_d = last_bit ? HOLD : LEAD;
      HOLD:    if (tick)  state_d = DONE;
      DONE:               state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sclk_o <= 1'b0;
      mosi_o <= 1'b0;
      cs_n_o <= '1;
      dout_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      cnt_q  <= (state_q == IDLE || state_q == DONE || tick) ? '0 : cnt_q + DIV_W'(1);

      if (lead_entry) begin
        sclk_o <= ~cpol_q;
        bit_q  <= lead_idx;
        if (cpha_q) mosi_o <= tx_q[bit_pos(lead_idx)];
        else        rx_q   <= shift_in(rx_q, miso_i);
      end

      if (trail_entry) begin
        sclk_o <= cpol_q;
        if (cpha_q)         rx_q   <= shift_in(rx_q, miso_i);
        else if (!last_bit) mosi_o <= tx_q[bit_pos(nxt_idx)];
      end

      case (state_q)
        IDLE: begin
          sclk_o <= cpol_i;
          bit_q  <= '0;
          if (str_i) begin
            tx_q   <= din_i;
            div_q  <= div_i;
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
            busy_o <= 1'b1;
            cs_n_o <= cs_decode(cs_sel_i);
            // With CPHA=0 the first bit must be on the line before the leading edge.
            if (!cpha_i) mosi_o <= din_i[bit_pos('0)];
          end
        end
        HOLD: if (tick) begin
          cs_n_o <= '1;
          dout_o <= rx_q;
          done_o <= 1'b1;
          mosi_o <= 1'b0;
        end
        DONE:    busy_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
